cpu_button_i: RTL and testbench

//  Avalon-MM slave input PIO: read-side counterpart of the cpu_*_o output ports.
//  - Samples external in_port through a synchroniser and an optional per-bit debouncer.
//  - Latches selected edges into a capture register and raises a maskable level IRQ to the CPU.
//  - Sits in the cpu system next to the output PIOs, on the same clock and reset.

---
 rtl/cpu_pio_defs.sv | 14 +
 rtl/cpu_button_i_if.sv | 26 ++
 rtl/cpu_button_i_debounce.sv | 47 ++++
 rtl/cpu_button_i.sv | 103 ++++++++++
 tb/tb_cpu_button_i.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pio_defs.sv
// Shared definitions for the cpu_* PIO blocks.
//  - Register word addresses on the Avalon-MM slave port.
//  - Edge-selection encodings for input PIOs.
package cpu_pio_defs;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/cpu_button_i_if.sv
// Avalon-MM slave bus of the cpu_button_i input PIO.
//  address    : word address (2 bits)
//  chipselect : slave select
//  write_n    : active-low write strobe
//  writedata  : write data (32 bits)
//  readdata   : combinational read data (32 bits)
//  irq        : level interrupt, active high
// master = CPU side, slave = PIO side.
interface cpu_button_i_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/cpu_button_i_debounce.sv
// One-bit debouncer for the cpu_button_i input PIO.
//  clk     : system clock
//  reset_n : asynchronous active-low reset
//  d       : synchronised input bit
//  q       : debounced bit; follows d only after it has differed from q
//            for DEBOUNCE_CYCLES consecutive clocks. DEBOUNCE_CYCLES = 0
//            passes d straight through with no register.
module cpu_button_i_debounce #(
  parameter int   DEBOUNCE_CYCLES = 0,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset_n;
      assign q = d;
    end else begin : g_filter
      localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);
      logic [15:0] cnt;
      logic        q_r;

      // Counter measures how long d has disagreed with q; any agreement restarts it.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt <= '0;
          q_r <= RESET_BIT;
        end else if (d == q_r) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          cnt <= '0;
          q_r <= d;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end

      assign q = q_r;
    end
  endgenerate

endmodule

// File: rtl/cpu_button_i.sv
// Avalon-MM slave input PIO (read-side counterpart of the cpu_*_o ports).
//  clk     : system clock
//  reset_n : asynchronous active-low reset
//  bus     : Avalon-MM slave (address, chipselect, write_n, writedata,
//            readdata, irq)
//  in_port : external asynchronous inputs
// Path: in_port -> 2-flop synchroniser -> per-bit debouncer -> edge detect
// -> edge_capture (W1C) -> irq = |(edge_capture & irq_mask).
// Map: 0 data (RO), 1 reserved, 2 irq_mask (RW), 3 edge_capture (W1C).
module cpu_button_i
  import cpu_pio_defs::*;
#(
  parameter int          WIDTH           = 16,
  parameter int          DEBOUNCE_CYCLES = 0,
  parameter int          EDGE_TYPE       = 0,
  parameter logic [31:0] RESET_VALUE     = 32'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  cpu_button_i_if.slave    bus,
  input  logic [WIDTH-1:0] in_port
);

  localparam logic [WIDTH-1:0] RST_LVL = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] sync1, sync2, stable, prev;
  logic [WIDTH-1:0] irq_mask, edge_capture;
  logic [WIDTH-1:0] edge_sel, clr;
  logic             wr_en;
  logic [31:0]      rdata;
  logic             unused_wd;

  assign unused_wd = ^bus.writedata;

  // Synchroniser stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RST_LVL;
      sync2 <= RST_LVL;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Debounce stage
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    cpu_button_i_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_BIT       (RST_LVL[i])
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (sync2[i]),
      .q       (stable[i])
    );
  end

  // Edge-detect stage; prev preloads to the reset level so release makes no edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= RST_LVL;
    else          prev <= stable;
  end

  always_comb begin
    edge_sel = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_sel = stable & ~prev;
      EDGE_FALL: edge_sel = ~stable & prev;
      EDGE_ANY:  edge_sel = stable ^ prev;
      default:   edge_sel = '0;
    endcase
  end

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign clr   = (wr_en && bus.address == PIO_ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

  // Capture and mask stage; OR-ing the edge after the clear lets a new edge beat a W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && bus.address == PIO_ADDR_IRQMASK)
        irq_mask <= bus.writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~clr) | edge_sel;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      PIO_ADDR_DATA:    rdata[WIDTH-1:0] = stable;
      PIO_ADDR_IRQMASK: rdata[WIDTH-1:0] = irq_mask;
      PIO_ADDR_EDGECAP: rdata[WIDTH-1:0] = edge_capture;
      default:          rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign bus.irq      = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_cpu_button_i.sv
// Directed bench for cpu_button_i.
//  dut_a: WIDTH 16, no debounce, rising edges.
//  dut_b: WIDTH 16, DEBOUNCE_CYCLES 4, any edge.
module tb_cpu_button_i;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic        cs_a = 1'b0;
  logic        cs_b = 1'b0;
  logic [15:0] in_a = 16'h0000;
  logic [15:0] in_b = 16'h0000;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  cpu_button_i_if bus_a ();
  cpu_button_i_if bus_b ();

  assign bus_a.address    = address;
  assign bus_a.chipselect = cs_a;
  assign bus_a.write_n    = write_n;
  assign bus_a.writedata  = writedata;
  assign bus_b.address    = address;
  assign bus_b.chipselect = cs_b;
  assign bus_b.write_n    = write_n;
  assign bus_b.writedata  = writedata;

  cpu_button_i #(.WIDTH(16), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .RESET_VALUE(32'd0)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a.slave),
    .in_port (in_a)
  );

  cpu_button_i #(.WIDTH(16), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .RESET_VALUE(32'd0)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b.slave),
    .in_port (in_b)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input bit sel, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    if (sel) cs_b = 1'b1; else cs_a = 1'b1;
    @(posedge clk);
    #1;
    cs_a    = 1'b0;
    cs_b    = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input bit sel, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    address = a;
    #1;
    d = sel ? bus_b.readdata : bus_a.readdata;
    chk(tag, d, exp);
  endtask

  task automatic chk_irq(input string tag, input bit sel, input logic exp);
    logic o;
    o = sel ? bus_b.irq : bus_a.irq;
    chk(tag, {31'd0, o}, {31'd0, exp});
  endtask

  initial begin
    // Reset state
    #2;
    chk_rd("rst_a0", 1'b0, 2'd0, 32'h0);
    chk_rd("rst_a1", 1'b0, 2'd1, 32'h0);
    chk_rd("rst_a2", 1'b0, 2'd2, 32'h0);
    chk_rd("rst_a3", 1'b0, 2'd3, 32'h0);
    chk_irq("rst_irq", 1'b0, 1'b0);
    cyc(2);
    reset_n = 1'b1;
    cyc(3);

    // Rising edge with no debounce
    wr(1'b0, 2'd2, 32'h0000_0004);
    in_a = 16'h0004;
    cyc(1);
    chk_rd("d0_e1_data", 1'b0, 2'd0, 32'h0);
    cyc(1);
    chk_rd("d0_e2_data", 1'b0, 2'd0, 32'h4);
    chk_rd("d0_e2_cap", 1'b0, 2'd3, 32'h0);
    cyc(1);
    chk_rd("d0_e3_cap", 1'b0, 2'd3, 32'h4);
    chk_rd("d0_e3_cap_reread", 1'b0, 2'd3, 32'h4);
    chk_irq("d0_e3_irq", 1'b0, 1'b1);
    wr(1'b0, 2'd3, 32'h0000_0004);
    chk_rd("d0_w1c_cap", 1'b0, 2'd3, 32'h0);
    chk_irq("d0_w1c_irq", 1'b0, 1'b0);

    // Mask gating
    wr(1'b0, 2'd2, 32'h0);
    in_a = 16'h0005;
    cyc(3);
    chk_rd("mask_cap", 1'b0, 2'd3, 32'h1);
    chk_irq("mask_irq_off", 1'b0, 1'b0);
    wr(1'b0, 2'd2, 32'h1);
    chk_irq("mask_irq_on", 1'b0, 1'b1);
    wr(1'b0, 2'd3, 32'h1);
    chk_irq("mask_irq_clr", 1'b0, 1'b0);

    // Edge and W1C in the same cycle on bit 3
    in_a = 16'h000D;
    cyc(3);
    chk_rd("sim_pre_cap", 1'b0, 2'd3, 32'h8);
    in_a = 16'h0005;
    cyc(3);
    chk_rd("sim_fall_ignored", 1'b0, 2'd3, 32'h8);
    in_a = 16'h000D;
    cyc(2);
    wr(1'b0, 2'd3, 32'h8);
    chk_rd("sim_edge_wins", 1'b0, 2'd3, 32'h8);
    wr(1'b0, 2'd3, 32'h8);
    chk_rd("sim_then_clear", 1'b0, 2'd3, 32'h0);

    // Width masking and ignored writes
    wr(1'b0, 2'd2, 32'hFFFF_FFFF);
    chk_rd("width_mask", 1'b0, 2'd2, 32'h0000_FFFF);
    wr(1'b0, 2'd0, 32'h0000_1234);
    chk_rd("ro_data", 1'b0, 2'd0, 32'h0000_000D);
    wr(1'b0, 2'd1, 32'hFFFF_FFFF);
    chk_rd("reserved", 1'b0, 2'd1, 32'h0);
    wr(1'b0, 2'd2, 32'h0);

    // Debounce, 4 cycles, any edge
    wr(1'b1, 2'd2, 32'h3);
    in_b = 16'h0001;
    cyc(3);
    in_b = 16'h0000;
    cyc(8);
    chk_rd("db_pulse_data", 1'b1, 2'd0, 32'h0);
    chk_rd("db_pulse_cap", 1'b1, 2'd3, 32'h0);
    in_b = 16'h0001;
    cyc(5);
    chk_rd("db_e5_data", 1'b1, 2'd0, 32'h0);
    cyc(1);
    chk_rd("db_e6_data", 1'b1, 2'd0, 32'h1);
    chk_rd("db_e6_cap", 1'b1, 2'd3, 32'h0);
    cyc(1);
    chk_rd("db_e7_cap", 1'b1, 2'd3, 32'h1);
    chk_irq("db_e7_irq", 1'b1, 1'b1);
    wr(1'b1, 2'd3, 32'h1);
    chk_irq("db_clr_irq", 1'b1, 1'b0);

    // Any edge on bit 1: rise then fall
    in_b = 16'h0003;
    cyc(7);
    chk_rd("any_rise", 1'b1, 2'd3, 32'h2);
    wr(1'b1, 2'd3, 32'h2);
    chk_rd("any_rise_clr", 1'b1, 2'd3, 32'h0);
    in_b = 16'h0001;
    cyc(7);
    chk_rd("any_fall", 1'b1, 2'd3, 32'h2);
    wr(1'b1, 2'd3, 32'h2);
    chk_rd("any_fall_clr", 1'b1, 2'd3, 32'h0);

    // Reset in the middle of a debounce count
    in_b = 16'h0003;
    cyc(4);
    reset_n = 1'b0;
    in_b = 16'h0000;
    in_a = 16'h0000;
    chk_rd("mid_rst_cap", 1'b1, 2'd3, 32'h0);
    chk_rd("mid_rst_mask", 1'b1, 2'd2, 32'h0);
    chk_rd("mid_rst_data", 1'b1, 2'd0, 32'h0);
    chk_rd("mid_rst_cap_a", 1'b0, 2'd3, 32'h0);
    reset_n = 1'b1;
    cyc(10);
    chk_rd("post_rst_cap", 1'b1, 2'd3, 32'h0);
    chk_rd("post_rst_data", 1'b1, 2'd0, 32'h0);
    chk_irq("post_rst_irq", 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
